// File: rtl/csr_access_ctrl.sv
// rtl/csr_access_ctrl.sv - CSR regfile access sequencer for CSR instructions, trap entry and mret
// Optional read-only space check enabled by defining CSR_RO_CHECK_EN.
`ifndef CSROP_LEN
`define CSROP_LEN   3
`define CSROP_NONE  3'd0
`define CSROP_WRITE 3'd1
`define CSROP_SET   3'd2
`define CSROP_CLEAR 3'd3
`define CSROP_READ  3'd4
`endif

module csr_access_ctrl #(
  parameter int          XLEN         = 64,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid_i,
  output logic                  inst_ready_o,
  input  logic [11:0]           inst_csr_addr_i,
  input  logic [`CSROP_LEN-1:0] inst_csr_op_i,
  input  logic [XLEN-1:0]       inst_op2_i,
  output logic [XLEN-1:0]       inst_rd_data_o,
  output logic                  inst_done_o,
  output logic                  inst_illegal_o,
  input  logic                  trap_valid_i,
  output logic                  trap_ready_o,
  input  logic                  trap_is_mret_i,
  input  logic [XLEN-1:0]       trap_pc_i,
  input  logic [XLEN-1:0]       trap_cause_i,
  output logic [XLEN-1:0]       trap_target_o,
  output logic                  trap_done_o,
  output logic [11:0]           csr_raddr_o,
  input  logic [XLEN-1:0]       csr_rdata_i,
  output logic                  csr_wen_o,
  output logic [11:0]           csr_waddr_o,
  output logic [XLEN-1:0]       csr_wdata_o,
  output logic                  busy_o
);

  typedef enum logic [3:0] {
    IDLE, INST_RD, INST_WR,
    TE_MEPC, TE_MCAUSE, TE_MST_RD, TE_MST_WR, TE_VEC_RD,
    MR_MST_RD, MR_MST_WR, MR_EPC_RD, DONE
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t                state, state_nxt;
  logic [11:0]           addr_q;
  logic [`CSROP_LEN-1:0] op_q;
  logic [XLEN-1:0]       op2_q, pc_q, cause_q, result_q;
  logic                  trap_acc, inst_acc, is_wr_op;

  assign busy_o       = (state != IDLE);
  assign trap_ready_o = (state == IDLE) & ~rst;
  assign inst_ready_o = (state == IDLE) & ~trap_valid_i & ~rst;
  assign trap_acc     = trap_valid_i & trap_ready_o;
  assign inst_acc     = inst_valid_i & inst_ready_o;
  assign is_wr_op     = (op_q == `CSROP_WRITE) | (op_q == `CSROP_SET) | (op_q == `CSROP_CLEAR);

  function automatic logic [XLEN-1:0] entry_mstatus(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r        = v;
    r[7]     = v[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r        = v;
    r[3]     = v[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b00;
    return r;
  endfunction

`ifdef CSR_RO_CHECK_EN
  // Any write into the read-only space is dropped; only ones that would change state are illegal.
  logic ro_space, ro_violation, illegal_q, wr_block_q;
  assign ro_space     = (addr_q[11:10] == 2'b11);
  assign ro_violation = ro_space & ((op_q == `CSROP_WRITE) |
                        (((op_q == `CSROP_SET) | (op_q == `CSROP_CLEAR)) & (|op2_q)));
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q  <= 1'b0;
      wr_block_q <= 1'b0;
    end else if (state == INST_RD) begin
      illegal_q  <= ro_violation;
      wr_block_q <= ro_space;
    end
  end
  assign inst_illegal_o = inst_done_o & illegal_q;
`else
  logic wr_block_q;
  assign wr_block_q     = 1'b0;
  assign inst_illegal_o = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    csr_raddr_o = '0;
    csr_wen_o   = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    inst_done_o = 1'b0;
    trap_done_o = 1'b0;
    case (state)
      IDLE: begin
        if (trap_acc)      state_nxt = trap_is_mret_i ? MR_MST_RD : TE_MEPC;
        else if (inst_acc) state_nxt = INST_RD;
      end
      INST_RD: begin
        csr_raddr_o = addr_q;
        state_nxt   = INST_WR;
      end
      INST_WR: begin
        inst_done_o = 1'b1;
        if (is_wr_op && !wr_block_q) begin
          csr_wen_o   = 1'b1;
          csr_waddr_o = addr_q;
          csr_wdata_o = result_q;
        end
        state_nxt = IDLE;
      end
      TE_MEPC: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = MEPC_ADDR;
        csr_wdata_o = pc_q & ALIGN_MASK;
        state_nxt   = TE_MCAUSE;
      end
      TE_MCAUSE: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = MCAUSE_ADDR;
        csr_wdata_o = cause_q;
        state_nxt   = TE_MST_RD;
      end
      TE_MST_RD: begin
        csr_raddr_o = MSTATUS_ADDR;
        state_nxt   = TE_MST_WR;
      end
      TE_MST_WR: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = MSTATUS_ADDR;
        csr_wdata_o = result_q;
        state_nxt   = TE_VEC_RD;
      end
      TE_VEC_RD: begin
        csr_raddr_o = MTVEC_ADDR;
        state_nxt   = DONE;
      end
      MR_MST_RD: begin
        csr_raddr_o = MSTATUS_ADDR;
        state_nxt   = MR_MST_WR;
      end
      MR_MST_WR: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = MSTATUS_ADDR;
        csr_wdata_o = result_q;
        state_nxt   = MR_EPC_RD;
      end
      MR_EPC_RD: begin
        csr_raddr_o = MEPC_ADDR;
        state_nxt   = DONE;
      end
      DONE: begin
        trap_done_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing may commit or complete while reset is asserted.
    if (rst) begin
      csr_wen_o   = 1'b0;
      csr_waddr_o = '0;
      csr_wdata_o = '0;
      inst_done_o = 1'b0;
      trap_done_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= '0;
      op_q           <= `CSROP_NONE;
      op2_q          <= '0;
      pc_q           <= '0;
      cause_q        <= '0;
      result_q       <= '0;
      inst_rd_data_o <= '0;
      trap_target_o  <= '0;
    end else begin
      if (trap_acc) begin
        pc_q    <= trap_pc_i;
        cause_q <= trap_cause_i;
      end else if (inst_acc) begin
        addr_q <= inst_csr_addr_i;
        op_q   <= inst_csr_op_i;
        op2_q  <= inst_op2_i;
      end
      case (state)
        INST_RD: begin
          inst_rd_data_o <= csr_rdata_i;
          case (op_q)
            `CSROP_WRITE: result_q <= op2_q;
            `CSROP_SET:   result_q <= csr_rdata_i | op2_q;
            `CSROP_CLEAR: result_q <= csr_rdata_i & ~op2_q;
            `CSROP_READ:  result_q <= csr_rdata_i;
            default:      result_q <= '0;
          endcase
        end
        TE_MST_RD: result_q      <= entry_mstatus(csr_rdata_i);
        MR_MST_RD: result_q      <= mret_mstatus(csr_rdata_i);
        TE_VEC_RD: trap_target_o <= csr_rdata_i & ALIGN_MASK;
        MR_EPC_RD: trap_target_o <= csr_rdata_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb/tb_csr_access_ctrl.sv - self-checking bench for csr_access_ctrl against a transaction-level model
`ifndef CSROP_LEN
`define CSROP_LEN   3
`define CSROP_NONE  3'd0
`define CSROP_WRITE 3'd1
`define CSROP_SET   3'd2
`define CSROP_CLEAR 3'd3
`define CSROP_READ  3'd4
`endif

module tb_csr_access_ctrl;

  logic        clk, rst;
  logic        inst_valid_i, inst_ready_o, inst_done_o, inst_illegal_o;
  logic [11:0] inst_csr_addr_i;
  logic [2:0]  inst_csr_op_i;
  logic [63:0] inst_op2_i, inst_rd_data_o;
  logic        trap_valid_i, trap_ready_o, trap_is_mret_i, trap_done_o;
  logic [63:0] trap_pc_i, trap_cause_i, trap_target_o;
  logic [11:0] csr_raddr_o, csr_waddr_o;
  logic [63:0] csr_rdata_i, csr_wdata_o;
  logic        csr_wen_o, busy_o;

  csr_access_ctrl dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_csr_addr_i(inst_csr_addr_i), .inst_csr_op_i(inst_csr_op_i),
    .inst_op2_i(inst_op2_i), .inst_rd_data_o(inst_rd_data_o),
    .inst_done_o(inst_done_o), .inst_illegal_o(inst_illegal_o),
    .trap_valid_i(trap_valid_i), .trap_ready_o(trap_ready_o),
    .trap_is_mret_i(trap_is_mret_i), .trap_pc_i(trap_pc_i),
    .trap_cause_i(trap_cause_i), .trap_target_o(trap_target_o),
    .trap_done_o(trap_done_o), .csr_raddr_o(csr_raddr_o),
    .csr_rdata_i(csr_rdata_i), .csr_wen_o(csr_wen_o),
    .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Register file seen by the DUT, plus a preload port for the stimulus.
  logic [63:0] mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [63:0] pre_data;
  assign csr_rdata_i = mem[csr_raddr_o];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      if (pre_en)    mem[pre_addr]    <= pre_data;
      if (csr_wen_o) mem[csr_waddr_o] <= csr_wdata_o;
    end
  end

  // One expected-output record per busy cycle of an accepted request.
  typedef struct {
    logic        wen;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic        chk_raddr;
    logic [11:0] raddr;
    logic        idone, ill, tdone;
    logic        set_rd;
    logic [63:0] rd;
    logic        set_tgt;
    logic [63:0] tgt;
  } exp_t;

  exp_t        q[$];
  logic [63:0] ref_mem [0:4095];
  logic [63:0] exp_rd, exp_tgt;

  function automatic exp_t blank();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic exp_t wr(input logic [11:0] a, input logic [63:0] d);
    exp_t e;
    e = blank();
    e.wen = 1'b1; e.waddr = a; e.wdata = d;
    return e;
  endfunction

  function automatic exp_t rd(input logic [11:0] a);
    exp_t e;
    e = blank();
    e.chk_raddr = 1'b1; e.raddr = a;
    return e;
  endfunction

  function automatic void model_inst();
    logic [11:0] a;
    logic [2:0]  op;
    logic [63:0] v, old, res;
    logic        wrop, blk, ill;
    exp_t        e;
    a = inst_csr_addr_i; op = inst_csr_op_i; v = inst_op2_i; old = ref_mem[a];
    case (op)
      `CSROP_WRITE: res = v;
      `CSROP_SET:   res = old | v;
      `CSROP_CLEAR: res = old & ~v;
      default:      res = old;
    endcase
    wrop = (op == `CSROP_WRITE) || (op == `CSROP_SET) || (op == `CSROP_CLEAR);
    blk = 1'b0; ill = 1'b0;
`ifdef CSR_RO_CHECK_EN
    if (a >= 12'hC00) begin
      blk = 1'b1;
      ill = (op == `CSROP_WRITE) || (wrop && v != 0);
    end
`endif
    q.push_back(rd(a));
    e = (wrop && !blk) ? wr(a, res) : blank();
    e.idone = 1'b1; e.ill = ill; e.set_rd = 1'b1; e.rd = old;
    q.push_back(e);
  endfunction

  function automatic void model_trap();
    logic [63:0] ms, nm;
    exp_t        e;
    ms = ref_mem[12'h300];
    nm = ms;
    e  = blank();
    e.tdone = 1'b1; e.set_tgt = 1'b1;
    if (!trap_is_mret_i) begin
      nm[7] = ms[3]; nm[3] = 1'b0; nm[12:11] = 2'b11;
      q.push_back(wr(12'h341, trap_pc_i - (trap_pc_i % 4)));
      q.push_back(wr(12'h342, trap_cause_i));
      q.push_back(rd(12'h300));
      q.push_back(wr(12'h300, nm));
      q.push_back(rd(12'h305));
      e.tgt = ref_mem[12'h305] - (ref_mem[12'h305] % 4);
    end else begin
      nm[3] = ms[7]; nm[7] = 1'b1; nm[12:11] = 2'b00;
      q.push_back(rd(12'h300));
      q.push_back(wr(12'h300, nm));
      q.push_back(rd(12'h341));
      e.tgt = ref_mem[12'h341];
    end
    q.push_back(e);
  endfunction

  initial begin
    exp_t e;
    exp_rd = '0; exp_tgt = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    forever begin
      @(posedge clk);
      if (pre_en) ref_mem[pre_addr] = pre_data;
      if (rst) begin
        q.delete();
        exp_rd = '0; exp_tgt = '0;
      end else if (q.size() != 0) begin
        e = q.pop_front();
        if (e.wen) ref_mem[e.waddr] = e.wdata;
      end else if (trap_valid_i) model_trap();
      else if (inst_valid_i) model_inst();
      if (!rst && q.size() != 0) begin
        if (q[0].set_rd)  exp_rd  = q[0].rd;
        if (q[0].set_tgt) exp_tgt = q[0].tgt;
      end
    end
  end

  initial begin
    exp_t e;
    logic idle;
    forever begin
      @(negedge clk);
      idle = (q.size() == 0);
      e = idle ? blank() : q[0];
      chk("busy", busy_o, !idle);
      chk("trap_ready", trap_ready_o, idle && !rst);
      chk("inst_ready", inst_ready_o, idle && !rst && !trap_valid_i);
      chk("wen", csr_wen_o, e.wen && !rst);
      chk("waddr", csr_waddr_o, rst ? 12'h0 : e.waddr);
      chk("wdata", csr_wdata_o, rst ? 64'h0 : e.wdata);
      if (e.chk_raddr) chk("raddr", csr_raddr_o, e.raddr);
      chk("inst_done", inst_done_o, e.idone && !rst);
      chk("illegal", inst_illegal_o, e.ill && !rst);
      chk("trap_done", trap_done_o, e.tdone && !rst);
      chk("rd_data", inst_rd_data_o, exp_rd);
      chk("target", trap_target_o, exp_tgt);
    end
  end

  logic        cap_wen, cap_ill;
  logic [63:0] cap_wdata, cap_rd, cap_tgt;

  task automatic set_reg(input logic [11:0] a, input logic [63:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_inst(input logic [11:0] a, input logic [2:0] op, input logic [63:0] v, output int lat);
    bit acc, dn;
    inst_csr_addr_i = a; inst_csr_op_i = op; inst_op2_i = v; inst_valid_i = 1'b1;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst_ready_o) begin acc = 1; break; end
    end
    chk("inst_accept", acc, 1);
    @(posedge clk); #1;
    inst_valid_i = 1'b0; inst_csr_addr_i = 12'hABC; inst_op2_i = '1; inst_csr_op_i = `CSROP_CLEAR;
    lat = 0; dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (inst_done_o) begin
        dn = 1; cap_wen = csr_wen_o; cap_wdata = csr_wdata_o; cap_rd = inst_rd_data_o; cap_ill = inst_illegal_o;
        break;
      end
    end
    chk("inst_done_seen", dn, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_trap(input logic is_mret, input logic [63:0] pc, input logic [63:0] cause, output int lat);
    bit acc, dn;
    trap_is_mret_i = is_mret; trap_pc_i = pc; trap_cause_i = cause; trap_valid_i = 1'b1;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (trap_ready_o) begin acc = 1; break; end
    end
    chk("trap_accept", acc, 1);
    @(posedge clk); #1;
    trap_valid_i = 1'b0; trap_is_mret_i = ~is_mret; trap_pc_i = '1; trap_cause_i = '1;
    lat = 0; dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (trap_done_o) begin dn = 1; cap_tgt = trap_target_o; break; end
    end
    chk("trap_done_seen", dn, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int  lat, n;
    bit  seen;
    rst = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    inst_valid_i = 1'b0; inst_csr_addr_i = '0; inst_csr_op_i = `CSROP_NONE; inst_op2_i = '0;
    trap_valid_i = 1'b0; trap_is_mret_i = 1'b0; trap_pc_i = '0; trap_cause_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_wen", csr_wen_o, 0);
    chk("reset_rd_data", inst_rd_data_o, 0);
    chk("reset_target", trap_target_o, 0);
    @(posedge clk); #1;

    set_reg(12'h340, 64'h1234);
    do_inst(12'h340, `CSROP_WRITE, 64'hDEAD, lat);
    chk("write_latency", lat, 2);
    chk("write_wen", cap_wen, 1);
    chk("write_wdata", cap_wdata, 64'hDEAD);
    chk("write_old", cap_rd, 64'h1234);

    set_reg(12'h340, 64'hF0);
    do_inst(12'h340, `CSROP_SET, 64'h0F, lat);
    chk("set_wdata", cap_wdata, 64'hFF);
    do_inst(12'h340, `CSROP_CLEAR, 64'h0F, lat);
    chk("clear_wdata", cap_wdata, 64'hF0);
    chk("clear_old", cap_rd, 64'hFF);
    do_inst(12'h340, `CSROP_READ, 64'h5, lat);
    chk("read_latency", lat, 2);
    chk("read_wen", cap_wen, 0);
    chk("read_old", cap_rd, 64'hF0);
    do_inst(12'h340, `CSROP_NONE, 64'h7, lat);
    chk("none_wen", cap_wen, 0);

    set_reg(12'h300, 64'h8);
    set_reg(12'h305, 64'h80001001);
    do_trap(1'b0, 64'h80000106, 64'd11, lat);
    chk("trap_latency", lat, 6);
    chk("trap_target", cap_tgt, 64'h80001000);
    chk("trap_mepc", mem[12'h341], 64'h80000104);
    chk("trap_mcause", mem[12'h342], 64'd11);
    chk("trap_mstatus", mem[12'h300], 64'h1880);

    do_trap(1'b1, 64'h0, 64'h0, lat);
    chk("mret_latency", lat, 4);
    chk("mret_target", cap_tgt, 64'h80000104);
    chk("mret_mstatus", mem[12'h300], 64'h88);

    // Simultaneous requests: trap first, instruction on the first idle cycle after trap_done.
    inst_csr_addr_i = 12'h340; inst_csr_op_i = `CSROP_SET; inst_op2_i = 64'h100; inst_valid_i = 1'b1;
    trap_is_mret_i = 1'b0; trap_pc_i = 64'h2002; trap_cause_i = 64'd3; trap_valid_i = 1'b1;
    @(negedge clk);
    chk("both_inst_ready", inst_ready_o, 0);
    chk("both_trap_ready", trap_ready_o, 1);
    @(posedge clk); #1;
    trap_valid_i = 1'b0;
    n = 0; seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (inst_ready_o) begin seen = 1; break; end
    end
    chk("both_inst_wait_seen", seen, 1);
    chk("both_inst_wait", n, 7);
    @(posedge clk); #1;
    inst_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("both_set_result", mem[12'h340], 64'h1F0);

    // Reset while the trap sequence sits in its mstatus read.
    set_reg(12'h300, 64'h8);
    trap_is_mret_i = 1'b0; trap_pc_i = 64'h10000000; trap_cause_i = 64'd7; trap_valid_i = 1'b1;
    @(negedge clk);
    chk("rst_trap_ready", trap_ready_o, 1);
    @(posedge clk); #1;
    trap_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_wen", csr_wen_o, 0);
    chk("rst_target", trap_target_o, 0);
    chk("rst_rd_data", inst_rd_data_o, 0);
    chk("rst_mepc_kept", mem[12'h341], 64'h10000000);
    chk("rst_mcause_kept", mem[12'h342], 64'd7);
    chk("rst_mstatus_untouched", mem[12'h300], 64'h8);
    @(posedge clk); #1;

    set_reg(12'hF11, 64'h55);
`ifdef CSR_RO_CHECK_EN
    do_inst(12'hF11, `CSROP_WRITE, 64'h1, lat);
    chk("ro_write_illegal", cap_ill, 1);
    chk("ro_write_wen", cap_wen, 0);
    chk("ro_write_old", cap_rd, 64'h55);
    do_inst(12'hF11, `CSROP_SET, 64'h0, lat);
    chk("ro_set0_illegal", cap_ill, 0);
    chk("ro_set0_wen", cap_wen, 0);
`else
    do_inst(12'hF11, `CSROP_WRITE, 64'h77, lat);
    chk("ro_off_illegal", cap_ill, 0);
    chk("ro_off_wen", cap_wen, 1);
    chk("ro_off_wdata", cap_wdata, 64'h77);
`endif
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
